// File: rtl/hazard_interlock_ctrl.sv
// ID-stage interlock controller: per-stage destination scoreboard, stall/bubble decision, stall stats.
// Define FORWARD_EN to reduce the interlock to load-use hazards against the EX entry only.
module hazard_interlock_ctrl #(
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned MAX_CONSEC  = 3
) (
    input  logic                   ip_clk,
    input  logic                   ip_reset,
    input  logic [31:0]            ip_instruction,
    input  logic                   ip_id_valid,
    input  logic                   ip_R_format,
    input  logic                   ip_I_format,
    input  logic                   ip_Lw,
    input  logic                   ip_Sw,
    input  logic                   ip_Beq,
    input  logic                   ip_RegWrite,
    input  logic [4:0]             ip_dest,
    input  logic                   ip_hold,
    output logic                   op_stall,
    output logic                   op_bubble,
    output logic                   op_RegWrite_EX,
    output logic                   op_RegWrite_MEM,
    output logic                   op_RegWrite_WB,
    output logic [4:0]             op_dest_EX,
    output logic [4:0]             op_dest_MEM,
    output logic [4:0]             op_dest_WB,
    output logic [STALL_CNT_W-1:0] op_stall_count,
    output logic                   op_state,
    output logic                   op_error
);

`ifdef FORWARD_EN
    localparam int unsigned ConsecLimit = 1;
`else
    localparam int unsigned ConsecLimit = MAX_CONSEC;
`endif
    localparam int unsigned ConsecW = $clog2(ConsecLimit + 2);

    typedef enum logic {StRun = 1'b0, StStall = 1'b1} state_e;

    state_e state_q, state_d;

    logic       rw_ex, rw_mem, rw_wb;
    logic [4:0] dest_ex, dest_mem, dest_wb;
    logic       load_ex, load_mem, load_wb;

    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [ConsecW-1:0]     consec_q;
    logic                   error_q;

    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic       hazard, issue;

    assign rs = ip_instruction[25:21];
    assign rt = ip_instruction[20:16];

    assign use_rs = ip_id_valid & (ip_R_format | ip_I_format | ip_Lw | ip_Sw | ip_Beq);
    assign use_rt = ip_id_valid & (ip_R_format | ip_Sw | ip_Beq);

    // $0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic stage_match(input logic rw, input logic [4:0] dest,
                                         input logic [4:0] src);
        return rw && (dest == src) && (dest != 5'd0);
    endfunction

    always_comb begin
        hazard = 1'b0;
`ifdef FORWARD_EN
        if (load_ex) begin
            hazard = (use_rs && stage_match(rw_ex, dest_ex, rs)) ||
                     (use_rt && stage_match(rw_ex, dest_ex, rt));
        end
`else
        hazard = (use_rs && (stage_match(rw_ex, dest_ex, rs) ||
                             stage_match(rw_mem, dest_mem, rs) ||
                             stage_match(rw_wb, dest_wb, rs))) ||
                 (use_rt && (stage_match(rw_ex, dest_ex, rt) ||
                             stage_match(rw_mem, dest_mem, rt) ||
                             stage_match(rw_wb, dest_wb, rt)));
`endif
    end

    assign op_stall  = hazard & ~ip_hold;
    assign op_bubble = op_stall;
    assign issue     = ip_id_valid & ~op_stall & ~ip_hold;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (op_stall) state_d = StStall;
            StStall: if (!hazard && !ip_hold) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge ip_clk or posedge ip_reset) begin
        if (ip_reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ip_clk or posedge ip_reset) begin
        if (ip_reset) begin
            rw_ex       <= 1'b0;
            rw_mem      <= 1'b0;
            rw_wb       <= 1'b0;
            dest_ex     <= 5'd0;
            dest_mem    <= 5'd0;
            dest_wb     <= 5'd0;
            load_ex     <= 1'b0;
            load_mem    <= 1'b0;
            load_wb     <= 1'b0;
            stall_cnt_q <= '0;
            consec_q    <= '0;
            error_q     <= 1'b0;
        end else if (!ip_hold) begin
            rw_wb    <= rw_mem;
            dest_wb  <= dest_mem;
            load_wb  <= load_mem;
            rw_mem   <= rw_ex;
            dest_mem <= dest_ex;
            load_mem <= load_ex;
            rw_ex    <= issue & ip_RegWrite;
            dest_ex  <= issue ? ip_dest : 5'd0;
            load_ex  <= issue & ip_Lw;
            if (op_stall) begin
                if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                end
                // Counter parks at the limit; one more stalled edge is an overrun.
                if (32'(consec_q) >= ConsecLimit) begin
                    error_q <= 1'b1;
                end else begin
                    consec_q <= consec_q + 1'b1;
                end
            end else begin
                consec_q <= '0;
            end
        end
    end

    assign op_RegWrite_EX  = rw_ex;
    assign op_RegWrite_MEM = rw_mem;
    assign op_RegWrite_WB  = rw_wb;
    assign op_dest_EX      = dest_ex;
    assign op_dest_MEM     = dest_mem;
    assign op_dest_WB      = dest_wb;
    assign op_stall_count  = stall_cnt_q;
    assign op_state        = state_q;
    assign op_error        = error_q;

    logic unused_bits;
    assign unused_bits = ^{ip_instruction[31:26], ip_instruction[15:0], load_mem, load_wb,
                           load_ex};

endmodule
